unidade_controle_multiciclo: RTL and testbench

Multicycle control FSM for the 64-bit LEGv8-subset processor. It sequences the shared add/sub memory-address datapath (operacao_memoria) plus the PC, IR, register file and the single shared memory port, one instruction at a time. It drives the operand-select code and add/sub control per state, and handles memory handshakes with a timeout.

---
 rtl/unidade_controle_multiciclo_pkg.sv | 44 ++++
 rtl/unidade_controle_multiciclo_decodificador_opcode.sv | 45 ++++
 rtl/unidade_controle_multiciclo.sv | 172 +++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared encodings for the multicycle LEGv8-subset control unit:
// opcodes, FSM states, datapath operand/offset selects and fault codes.
package unidade_controle_multiciclo_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB     = 3'b100,
    ST_FAULT  = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  localparam logic [1:0] OP_AB   = 2'b00;
  localparam logic [1:0] OP_BOFF = 2'b01;
  localparam logic [1:0] OP_AOFF = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

  localparam logic [1:0] IMM_D  = 2'b00;
  localparam logic [1:0] IMM_I  = 2'b01;
  localparam logic [1:0] IMM_CB = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador_opcode.sv
// Combinational opcode decoder: instruction class, legality, add/sub
// control and offset format, all derived from the IR opcode field.
module decodificador_opcode
  import unidade_controle_multiciclo_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls_o,
  output logic         legal_o,
  output logic         add_sub_o,
  output logic [1:0]   imm_sel_o
);

  // Register and offset fields are consumed by the datapath, not here.
  logic unused_fields;
  assign unused_fields = ^instr[20:0];

  always_comb begin
    cls_o     = CLS_ILLEGAL;
    add_sub_o = 1'b0;
    imm_sel_o = IMM_D;
    if (instr[31:21] == OPC_ADD) begin
      cls_o = CLS_R;
    end else if (instr[31:21] == OPC_SUB) begin
      cls_o     = CLS_R;
      add_sub_o = 1'b1;
    end else if (instr[31:21] == OPC_LDUR) begin
      cls_o = CLS_LDUR;
    end else if (instr[31:21] == OPC_STUR) begin
      cls_o = CLS_STUR;
    end else if (instr[31:22] == OPC_ADDI) begin
      cls_o     = CLS_I;
      imm_sel_o = IMM_I;
    end else if (instr[31:22] == OPC_SUBI) begin
      cls_o     = CLS_I;
      add_sub_o = 1'b1;
      imm_sel_o = IMM_I;
    end else if (instr[31:24] == OPC_CBZ) begin
      cls_o     = CLS_CBZ;
      imm_sel_o = IMM_CB;
    end
  end

  assign legal_o = (cls_o != CLS_ILLEGAL);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky FAULT
// state entered on an illegal opcode or a memory handshake timeout.
module unidade_controle_multiciclo
  import unidade_controle_multiciclo_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        rb_zero,
  input  logic        mem_ack,
  output logic [1:0]  OP_MEM_I,
  output logic        ADD_SUB,
  output logic [1:0]  imm_sel,
  output logic        addr_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [2:0]  state
);

  // Handshake: mem_req stays high in FETCH/MEM until the cycle where
  // mem_ack is sampled high; that same cycle completes the transfer.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   fault_code_q, fault_code_d;
  instr_class_t cls;
  logic         legal;
  logic         dec_add_sub;
  logic [1:0]   dec_imm_sel;
  logic         timeout;

  decodificador_opcode u_dec (
    .instr     (instr),
    .cls_o     (cls),
    .legal_o   (legal),
    .add_sub_o (dec_add_sub),
    .imm_sel_o (dec_imm_sel)
  );

  // Counter holds the number of ack-less cycles already spent waiting.
  assign timeout = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      cnt_q        <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_R, CLS_I:       state_d = ST_WB;
          CLS_LDUR, CLS_STUR: state_d = ST_MEM;
          default:            state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = (cls == CLS_LDUR) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WB:    state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d      = ST_FAULT;
        fault_code_d = FAULT_ILLEGAL;
      end
    endcase
  end

  always_comb begin
    OP_MEM_I  = OP_ZERO;
    ADD_SUB   = 1'b0;
    imm_sel   = IMM_D;
    addr_sel  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack;
        pc_write = mem_ack;
      end
      // MEM keeps the EXEC selects so the computed address stays stable.
      ST_EXEC, ST_MEM: begin
        ADD_SUB = dec_add_sub;
        imm_sel = dec_imm_sel;
        case (cls)
          CLS_R:                      OP_MEM_I = OP_AB;
          CLS_I, CLS_LDUR, CLS_STUR:  OP_MEM_I = OP_AOFF;
          default:                    OP_MEM_I = OP_ZERO;
        endcase
        if (state_q == ST_EXEC) begin
          if (cls == CLS_CBZ) begin
            pc_write = rb_zero;
            pc_src   = rb_zero;
          end
        end else begin
          addr_sel = 1'b1;
          mem_req  = 1'b1;
          mem_we   = (cls == CLS_STUR);
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (cls == CLS_LDUR);
      end
      default: ;
    endcase
    // Strobes drop the moment reset asserts, even mid-transfer.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Randomized self-checking bench: a per-instruction sequence model builds the
// expected output of every cycle, which is compared against the control unit.
module tb_unidade_controle_multiciclo;

  localparam int T = 16;
  localparam int W = 19;

  // Instruction kinds used by the reference model.
  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_SUBI = 3;
  localparam int K_LDUR = 4, K_STUR = 5, K_CBZ = 6, K_ILL = 7;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        rb_zero;
  logic        mem_ack;
  logic [1:0]  OP_MEM_I;
  logic        ADD_SUB;
  logic [1:0]  imm_sel;
  logic        addr_sel;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic        pc_src;
  logic        reg_write;
  logic        wb_sel;
  logic        fault;
  logic [1:0]  fault_code;
  logic [2:0]  state;

  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic         ack_q[$];
  logic [31:0]  ins_q[$];
  logic [31:0]  ir_model;
  int           n_checks;
  int           n_errors;

  unidade_controle_multiciclo #(.MEM_TIMEOUT(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .rb_zero    (rb_zero),
    .mem_ack    (mem_ack),
    .OP_MEM_I   (OP_MEM_I),
    .ADD_SUB    (ADD_SUB),
    .imm_sel    (imm_sel),
    .addr_sel   (addr_sel),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .fault      (fault),
    .fault_code (fault_code),
    .state      (state)
  );

  assign obs = {state, OP_MEM_I, ADD_SUB, imm_sel, addr_sel, mem_req, mem_we,
                ir_write, pc_write, pc_src, reg_write, wb_sel, fault, fault_code};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [1:0] op,
      input logic as, input logic [1:0] imm, input logic asel, input logic req,
      input logic we, input logic irw, input logic pcw, input logic pcs,
      input logic rw, input logic wbs, input logic flt, input logic [1:0] fc);
    return {st, op, as, imm, asel, req, we, irw, pcw, pcs, rw, wbs, flt, fc};
  endfunction

  // Fields checked in every state, plus the selects each state defines.
  function automatic logic [W-1:0] m_core();
    return mk(3'b111, 2'b00, 0, 2'b00, 0, 1, 1, 1, 1, 0, 1, 0, 1, 2'b11);
  endfunction
  function automatic logic [W-1:0] f_sel();
    return mk(3'b000, 2'b11, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] f_imm();
    return mk(3'b000, 2'b00, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] f_asel();
    return mk(3'b000, 2'b00, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] f_pcs();
    return mk(3'b000, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] f_wbs();
    return mk(3'b000, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] v_reset();
    return mk(3'd0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endfunction

  function automatic int classify(input logic [31:0] ins);
    logic [10:0] o11;
    logic [9:0]  o10;
    logic [7:0]  o8;
    o11 = ins[31:21];
    o10 = ins[31:22];
    o8  = ins[31:24];
    if (o11 == 11'b10001011000) return K_ADD;
    if (o11 == 11'b11001011000) return K_SUB;
    if (o11 == 11'b11111000010) return K_LDUR;
    if (o11 == 11'b11111000000) return K_STUR;
    if (o10 == 10'b1001000100)  return K_ADDI;
    if (o10 == 10'b1101000100)  return K_SUBI;
    if (o8  == 8'b10110100)     return K_CBZ;
    return K_ILL;
  endfunction

  task automatic push(input logic [W-1:0] e, input logic [W-1:0] m, input logic a,
                      input logic [31:0] iv);
    exp_q.push_back(e);
    msk_q.push_back(m);
    ack_q.push_back(a);
    ins_q.push_back(iv);
  endtask

  task automatic push_fault(input logic [1:0] code, input logic [31:0] iv);
    repeat (4)
      push(mk(3'd5, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, code), m_core(),
           1'($urandom_range(0, 1)), iv);
  endtask

  // One waiting phase on the memory port: dly ack-less cycles, then ack.
  // Returns 1 when dly reaches the timeout and the phase ends in FAULT.
  task automatic push_wait(input logic [W-1:0] v, input logic [W-1:0] m, input int dly,
                           input logic [31:0] iv, output bit timed_out);
    timed_out = (dly >= T);
    if (timed_out) begin
      repeat (T) push(v, m, 1'b0, iv);
      push_fault(2'b10, iv);
    end else begin
      repeat (dly) push(v, m, 1'b0, iv);
    end
  endtask

  task automatic model_instr(input logic [31:0] ins, input int fd, input int md,
                             input logic rbz, output bit faulted);
    int k;
    bit to;
    logic sub;
    logic [W-1:0] ex, mv, m_fetch;
    m_fetch = m_core() | f_asel() | f_pcs();
    faulted = 1'b0;
    push_wait(mk(3'd0, 2'b11, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00), m_fetch,
              fd, ir_model, to);
    if (to) begin
      faulted = 1'b1;
      return;
    end
    push(mk(3'd0, 2'b11, 0, 2'b00, 0, 1, 0, 1, 1, 0, 0, 0, 0, 2'b00), m_fetch, 1'b1, ir_model);
    ir_model = ins;
    push(mk(3'd1, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), m_core(),
         1'($urandom_range(0, 1)), ins);
    k = classify(ins);
    sub = (k == K_SUB) || (k == K_SUBI);
    case (k)
      K_ILL: begin
        push_fault(2'b01, ins);
        faulted = 1'b1;
      end
      K_CBZ: begin
        push(mk(3'd2, 2'b11, 0, 2'b10, 0, 0, 0, 0, rbz, rbz, 0, 0, 0, 2'b00),
             m_core() | f_imm() | f_pcs(), 1'($urandom_range(0, 1)), ins);
      end
      K_LDUR, K_STUR: begin
        ex = mk(3'd2, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        push(ex, m_core() | f_sel(), 1'($urandom_range(0, 1)), ins);
        mv = mk(3'd3, 2'b10, 0, 2'b00, 1, 1, (k == K_STUR), 0, 0, 0, 0, 0, 0, 2'b00);
        push_wait(mv, m_core() | f_sel() | f_asel(), md, ins, to);
        if (to) begin
          faulted = 1'b1;
        end else begin
          push(mv, m_core() | f_sel() | f_asel(), 1'b1, ins);
          if (k == K_LDUR)
            push(mk(3'd4, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00),
                 m_core() | f_wbs(), 1'($urandom_range(0, 1)), ins);
        end
      end
      default: begin
        if (k == K_ADD || k == K_SUB)
          ex = mk(3'd2, 2'b00, sub, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        else
          ex = mk(3'd2, 2'b10, sub, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        push(ex, m_core() | f_sel(), 1'($urandom_range(0, 1)), ins);
        push(mk(3'd4, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00),
             m_core() | f_wbs(), 1'($urandom_range(0, 1)), ins);
      end
    endcase
  endtask

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic run_cycles(input int n);
    int done;
    logic [W-1:0] e, m;
    done = 0;
    while (exp_q.size() != 0 && (n < 0 || done < n)) begin
      mem_ack = ack_q.pop_front();
      instr   = ins_q.pop_front();
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      #1;
      check($sformatf("cycle_st%0d", e[18:16]), obs & m, e & m);
      done++;
      @(negedge clk);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    msk_q.delete();
    ack_q.delete();
    ins_q.delete();
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases on a falling edge.
  task automatic reset_now(input string tag);
    #3;
    rst_n   = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    #1;
    check(tag, obs, v_reset());
    @(negedge clk);
    #1;
    check({tag, "_hold"}, obs, v_reset());
    @(negedge clk);
    rst_n   = 1'b1;
    mem_ack = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fd, input int md,
                           input logic rbz);
    bit faulted;
    rb_zero = rbz;
    model_instr(ins, fd, md, rbz, faulted);
    run_cycles(-1);
    if (faulted) reset_now("reset_after_fault");
  endtask

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return $urandom_range(0, 2);
    if (r < 18) return T - 1;
    if (r == 18) return T;
    return $urandom_range(0, T - 1);
  endfunction

  function automatic logic [31:0] gen_instr(input int kind);
    logic [31:0] r;
    r = $urandom();
    case (kind)
      K_ADD:   return {11'b10001011000, r[20:0]};
      K_SUB:   return {11'b11001011000, r[20:0]};
      K_ADDI:  return {10'b1001000100, r[21:0]};
      K_SUBI:  return {10'b1101000100, r[21:0]};
      K_LDUR:  return {11'b11111000010, r[20:0]};
      K_STUR:  return {11'b11111000000, r[20:0]};
      K_CBZ:   return {8'b10110100, r[23:0]};
      K_ILL:   return 32'h0000_0000;
      default: return r;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit faulted;
    n_checks = 0;
    n_errors = 0;
    ir_model = 32'h0;
    rst_n    = 1'b0;
    instr    = 32'h0;
    rb_zero  = 1'b0;
    mem_ack  = 1'b0;
    @(negedge clk);
    #1;
    check("reset_state", obs, v_reset());
    mem_ack = 1'b1;
    #1;
    check("reset_ack_ignored", obs, v_reset());
    @(negedge clk);
    rst_n   = 1'b1;
    mem_ack = 1'b0;

    run_instr(32'h8B02_0023, 0, 0, 1'b0);
    run_instr(32'hCB02_0023, 0, 0, 1'b0);
    run_instr(32'hF840_8041, 0, 3, 1'b0);
    run_instr(32'hF800_8041, 0, 0, 1'b0);
    run_instr(32'hB400_0041, 0, 0, 1'b1);
    run_instr(32'hB400_0041, 1, 0, 1'b0);
    run_instr(32'h9100_1441, 0, 0, 1'b0);
    run_instr(32'hD100_1441, 2, 0, 1'b1);
    run_instr(32'h0000_0000, 0, 0, 1'b0);
    run_instr(32'h8B02_0023, T - 1, 0, 1'b0);
    run_instr(32'h8B02_0023, T, 0, 1'b0);
    run_instr(32'hF800_8041, 0, T - 1, 1'b0);
    run_instr(32'hF840_8041, 0, T, 1'b0);

    // Reset while FETCH waits, then while MEM waits.
    model_instr(32'h8B02_0023, 10, 0, 1'b0, faulted);
    run_cycles(3);
    flush_model();
    reset_now("async_reset_fetch");
    model_instr(32'hF840_8041, 0, 10, 1'b0, faulted);
    run_cycles(5);
    flush_model();
    reset_now("async_reset_mem");
    ir_model = 32'h0;

    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = $urandom_range(0, 8);
      run_instr(gen_instr(kind), pick_dly(), pick_dly(), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
